// File: rtl/alarm_unit.sv
// Alarm clock controller: alarm-time adjust, arm/ring/snooze FSM with timed auto-stop.
// Define ALARM_SNOOZE_EN to enable the snooze state and its counter.
`timescale 1ns/1ps
module alarm_unit #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1s,
  input  logic [12:0] time_bcd,
  input  logic        set_en,
  input  logic        inc_min,
  input  logic        dec_min,
  input  logic        inc_hr,
  input  logic        dec_hr,
  input  logic        arm,
  input  logic        stop,
  input  logic        snooze,
  output logic [12:0] alarm_bcd,
  output logic        ringing,
  output logic        buzzer,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZE  = 2'b11
  } state_t;

  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW       = $clog2(MAX_SECS + 1);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);

  state_t        state, state_n;
  logic [CW-1:0] ring_cnt;
  logic          beep, beep_n;
  logic          match, match_q;
  logic          snooze_req;
  logic          snooze_done;
  logic [12:0]   alarm_n;

  // Minutes field {tens[2:0], units[3:0]}, BCD 00..59, no carry out.
  function automatic logic [6:0] min_inc(input logic [6:0] m);
    if (m[3:0] == 4'd9)
      return (m[6:4] == 3'd5) ? 7'h00 : {m[6:4] + 3'd1, 4'd0};
    return {m[6:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] min_dec(input logic [6:0] m);
    if (m[3:0] == 4'd0)
      return (m[6:4] == 3'd0) ? 7'h59 : {m[6:4] - 3'd1, 4'd9};
    return {m[6:4], m[3:0] - 4'd1};
  endfunction

  // Hours field {tens[1:0], units[3:0]}, BCD 00..23.
  function automatic logic [5:0] hr_inc(input logic [5:0] h);
    if (h == 6'h23)
      return 6'h00;
    if (h[3:0] == 4'd9)
      return {h[5:4] + 2'd1, 4'd0};
    return {h[5:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] hr_dec(input logic [5:0] h);
    if (h == 6'h00)
      return 6'h23;
    if (h[3:0] == 4'd0)
      return {h[5:4] - 2'd1, 4'd9};
    return {h[5:4], h[3:0] - 4'd1};
  endfunction

  assign match   = (time_bcd == alarm_bcd);
  assign state_o = state;

`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);
  logic [CW-1:0] snooze_cnt;

  assign snooze_req  = snooze;
  assign snooze_done = tick_1s && (snooze_cnt == SNOOZE_LAST);

  always_ff @(posedge clk) begin
    if (reset)
      snooze_cnt <= '0;
    else if (state == SNOOZE && state_n == SNOOZE)
      snooze_cnt <= snooze_cnt + CW'(tick_1s);
    else
      snooze_cnt <= '0;
  end
`else
  logic unused_snooze;

  assign snooze_req    = 1'b0;
  assign snooze_done   = 1'b0;
  assign unused_snooze = snooze;
`endif

  always_comb begin
    alarm_n = alarm_bcd;
    if (set_en) begin
      if (inc_min && !dec_min)
        alarm_n[6:0] = min_inc(alarm_bcd[6:0]);
      else if (dec_min && !inc_min)
        alarm_n[6:0] = min_dec(alarm_bcd[6:0]);
      if (inc_hr && !dec_hr)
        alarm_n[12:7] = hr_inc(alarm_bcd[12:7]);
      else if (dec_hr && !inc_hr)
        alarm_n[12:7] = hr_dec(alarm_bcd[12:7]);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arm && !set_en) state_n = ARMED;
      ARMED:   if (match && !match_q && !set_en) state_n = RINGING;
      RINGING: begin
        if (stop)
          state_n = ARMED;
        else if (snooze_req)
          state_n = SNOOZE;
        else if (tick_1s && ring_cnt == RING_LAST)
          state_n = ARMED;
      end
      SNOOZE: begin
        if (stop)
          state_n = ARMED;
        else if (snooze_done)
          state_n = RINGING;
      end
    endcase
    if (!arm)
      state_n = IDLE;
  end

  // Beep only runs while staying in RINGING, so every ring episode starts silent.
  assign beep_n = (state == RINGING && state_n == RINGING) ? (beep ^ tick_1s) : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      alarm_bcd <= '0;
      ring_cnt  <= '0;
      beep      <= 1'b0;
      match_q   <= 1'b0;
      ringing   <= 1'b0;
      buzzer    <= 1'b0;
    end else begin
      state     <= state_n;
      alarm_bcd <= alarm_n;
      match_q   <= match;
      beep      <= beep_n;
      ringing   <= (state_n == RINGING);
      buzzer    <= (state_n == RINGING) && beep_n;
      if (state == RINGING && state_n == RINGING)
        ring_cnt <= ring_cnt + CW'(tick_1s);
      else
        ring_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit; follows ALARM_SNOOZE_EN when compiled in.
`timescale 1ns/1ps
module tb_alarm_unit;

  logic        clk = 1'b0;
  logic        reset, tick_1s, set_en, inc_min, dec_min, inc_hr, dec_hr, arm, stop, snooze;
  logic [12:0] time_bcd, alarm_bcd;
  logic        ringing, buzzer;
  logic [1:0]  state_o;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alarm_unit #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .time_bcd(time_bcd),
    .set_en(set_en), .inc_min(inc_min), .dec_min(dec_min), .inc_hr(inc_hr),
    .dec_hr(dec_hr), .arm(arm), .stop(stop), .snooze(snooze),
    .alarm_bcd(alarm_bcd), .ringing(ringing), .buzzer(buzzer), .state_o(state_o)
  );

  function automatic logic [12:0] hm(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1s = 1'b1; cyc(); tick_1s = 1'b0; cyc();
  endtask

  task automatic ring_up();
    time_bcd = hm(7, 29); cyc();
    time_bcd = hm(7, 30); cyc();
  endtask

  task automatic test_reset();
    {tick_1s, set_en, inc_min, dec_min, inc_hr, dec_hr, arm, stop, snooze} = '0;
    time_bcd = '0;
    reset = 1'b1; cyc(); cyc();
    total++; if (state_o !== 2'b00) begin bad++; $display("FAIL rst_state got=%b want=00", state_o); end
    total++; if (alarm_bcd !== 13'h0) begin bad++; $display("FAIL rst_alarm got=%h want=0000", alarm_bcd); end
    total++; if (ringing !== 1'b0 || buzzer !== 1'b0) begin bad++; $display("FAIL rst_outs ringing=%b buzzer=%b want=0,0", ringing, buzzer); end
    reset = 1'b0; cyc();
  endtask

  task automatic test_adjust();
    set_en = 1'b1;
    dec_hr = 1'b1; cyc(); dec_hr = 1'b0; cyc();
    total++; if (alarm_bcd !== hm(23, 0)) begin bad++; $display("FAIL adj_hr_wrap got=%h want=%h", alarm_bcd, hm(23, 0)); end
    for (int i = 0; i < 2; i++) begin dec_hr = 1'b1; cyc(); dec_hr = 1'b0; cyc(); end
    for (int i = 0; i < 2; i++) begin inc_min = 1'b1; cyc(); inc_min = 1'b0; cyc(); end
    total++; if (alarm_bcd !== hm(21, 2)) begin bad++; $display("FAIL adj_21_02 got=%h want=%h", alarm_bcd, hm(21, 2)); end
    set_en = 1'b0;
    inc_min = 1'b1; cyc(); inc_min = 1'b0; cyc();
    total++; if (alarm_bcd !== hm(21, 2)) begin bad++; $display("FAIL adj_no_set_en got=%h want=%h", alarm_bcd, hm(21, 2)); end
  endtask

  task automatic test_wrap();
    set_en = 1'b1;
    for (int i = 0; i < 2; i++) begin inc_hr = 1'b1; cyc(); inc_hr = 1'b0; end
    for (int i = 0; i < 3; i++) begin dec_min = 1'b1; cyc(); dec_min = 1'b0; end
    total++; if (alarm_bcd !== hm(23, 59)) begin bad++; $display("FAIL wrap_23_59 got=%h want=%h", alarm_bcd, hm(23, 59)); end
    inc_hr = 1'b1; inc_min = 1'b1; cyc(); inc_hr = 1'b0; inc_min = 1'b0;
    total++; if (alarm_bcd !== hm(0, 0)) begin bad++; $display("FAIL wrap_00_00 got=%h want=%h", alarm_bcd, hm(0, 0)); end
    inc_min = 1'b1; cyc();
    dec_min = 1'b1; cyc(); inc_min = 1'b0; dec_min = 1'b0;
    total++; if (alarm_bcd !== hm(0, 1)) begin bad++; $display("FAIL min_inc_dec got=%h want=%h", alarm_bcd, hm(0, 1)); end
    inc_hr = 1'b1; dec_hr = 1'b1; inc_min = 1'b1; cyc(); {inc_hr, dec_hr, inc_min} = '0;
    total++; if (alarm_bcd !== hm(0, 2)) begin bad++; $display("FAIL hr_inc_dec got=%h want=%h", alarm_bcd, hm(0, 2)); end
    for (int i = 0; i < 3; i++) begin dec_min = 1'b1; cyc(); dec_min = 1'b0; end
    total++; if (alarm_bcd !== hm(0, 59)) begin bad++; $display("FAIL min_no_borrow got=%h want=%h", alarm_bcd, hm(0, 59)); end
    set_en = 1'b0; cyc();
  endtask

  task automatic test_match();
    reset = 1'b1; cyc(); reset = 1'b0;
    set_en = 1'b1;
    for (int i = 0; i < 7; i++) begin inc_hr = 1'b1; cyc(); inc_hr = 1'b0; end
    for (int i = 0; i < 30; i++) begin inc_min = 1'b1; cyc(); inc_min = 1'b0; end
    total++; if (alarm_bcd !== hm(7, 30)) begin bad++; $display("FAIL set_07_30 got=%h want=%h", alarm_bcd, hm(7, 30)); end
    set_en = 1'b0; time_bcd = hm(7, 29); arm = 1'b1; cyc();
    total++; if (state_o !== 2'b01) begin bad++; $display("FAIL arm_state got=%b want=01", state_o); end
    cyc();
    time_bcd = hm(7, 30); #1;
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL ring_early got=%b want=0", ringing); end
    cyc();
    total++; if (ringing !== 1'b1 || state_o !== 2'b10) begin bad++; $display("FAIL ring_latency ringing=%b state=%b want=1,10", ringing, state_o); end
    stop = 1'b1; cyc(); stop = 1'b0;
    total++; if (state_o !== 2'b01 || ringing !== 1'b0) begin bad++; $display("FAIL stop_ring state=%b ringing=%b want=01,0", state_o, ringing); end
    repeat (5) cyc();
    total++; if (state_o !== 2'b01 || ringing !== 1'b0) begin bad++; $display("FAIL no_retrigger state=%b ringing=%b want=01,0", state_o, ringing); end
  endtask

  task automatic test_ring_timeout();
    ring_up();
    total++; if (ringing !== 1'b1 || buzzer !== 1'b0) begin bad++; $display("FAIL ring_entry ringing=%b buzzer=%b want=1,0", ringing, buzzer); end
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i < 60) begin
        total++; if (ringing !== 1'b1) begin bad++; $display("FAIL ring_hold tick=%0d got=%b want=1", i, ringing); end
        total++; if (buzzer !== 1'(i % 2)) begin bad++; $display("FAIL buzz_toggle tick=%0d got=%b want=%0d", i, buzzer, i % 2); end
      end
    end
    total++; if (state_o !== 2'b01 || ringing !== 1'b0 || buzzer !== 1'b0)
      begin bad++; $display("FAIL ring_timeout state=%b ringing=%b buzzer=%b want=01,0,0", state_o, ringing, buzzer); end
  endtask

  task automatic test_snooze();
    ring_up();
    snooze = 1'b1; cyc(); snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    total++; if (state_o !== 2'b11 || ringing !== 1'b0) begin bad++; $display("FAIL snooze_enter state=%b ringing=%b want=11,0", state_o, ringing); end
    for (int i = 0; i < 299; i++) tick();
    total++; if (state_o !== 2'b11) begin bad++; $display("FAIL snooze_299 got=%b want=11", state_o); end
    tick();
    total++; if (state_o !== 2'b10 || ringing !== 1'b1) begin bad++; $display("FAIL snooze_300 state=%b ringing=%b want=10,1", state_o, ringing); end
`else
    total++; if (state_o !== 2'b10 || ringing !== 1'b1) begin bad++; $display("FAIL snooze_ignored state=%b ringing=%b want=10,1", state_o, ringing); end
    repeat (3) cyc();
    total++; if (state_o !== 2'b10) begin bad++; $display("FAIL snooze_unreach got=%b want=10", state_o); end
`endif
    stop = 1'b1; cyc(); stop = 1'b0;
    total++; if (state_o !== 2'b01) begin bad++; $display("FAIL snooze_stop got=%b want=01", state_o); end
  endtask

  task automatic test_disarm();
    ring_up();
    set_en = 1'b1; inc_min = 1'b1; cyc(); inc_min = 1'b0; set_en = 1'b0;
    total++; if (state_o !== 2'b10 || alarm_bcd !== hm(7, 31)) begin bad++; $display("FAIL adj_in_ring state=%b alarm=%h want=10,%h", state_o, alarm_bcd, hm(7, 31)); end
    arm = 1'b0; cyc();
    total++; if (state_o !== 2'b00 || ringing !== 1'b0) begin bad++; $display("FAIL disarm state=%b ringing=%b want=00,0", state_o, ringing); end
    time_bcd = hm(7, 0); set_en = 1'b1; arm = 1'b1; cyc();
    total++; if (state_o !== 2'b00) begin bad++; $display("FAIL arm_blocked got=%b want=00", state_o); end
    dec_min = 1'b1; cyc(); dec_min = 1'b0; set_en = 1'b0; cyc();
    total++; if (state_o !== 2'b01 || alarm_bcd !== hm(7, 30)) begin bad++; $display("FAIL rearm state=%b alarm=%h want=01,%h", state_o, alarm_bcd, hm(7, 30)); end
  endtask

  task automatic test_stop_snooze();
    ring_up();
    stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
    total++; if (state_o !== 2'b01 || ringing !== 1'b0) begin bad++; $display("FAIL stop_wins state=%b ringing=%b want=01,0", state_o, ringing); end
    ring_up();
    tick();
    total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL buzz_before_rst got=%b want=1", buzzer); end
    reset = 1'b1; arm = 1'b0; cyc();
    total++; if (state_o !== 2'b00 || ringing !== 1'b0 || buzzer !== 1'b0 || alarm_bcd !== 13'h0)
      begin bad++; $display("FAIL rst_mid_ring state=%b ringing=%b buzzer=%b alarm=%h want=00,0,0,0000", state_o, ringing, buzzer, alarm_bcd); end
    reset = 1'b0;
`ifdef ALARM_SNOOZE_EN
    set_en = 1'b1;
    for (int i = 0; i < 7; i++) begin inc_hr = 1'b1; cyc(); inc_hr = 1'b0; end
    for (int i = 0; i < 30; i++) begin dec_min = 1'b1; cyc(); dec_min = 1'b0; end
    set_en = 1'b0; time_bcd = hm(7, 29); arm = 1'b1; cyc();
    ring_up();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    repeat (3) tick();
    total++; if (state_o !== 2'b11) begin bad++; $display("FAIL pre_rst_snooze got=%b want=11", state_o); end
    reset = 1'b1; arm = 1'b0; cyc(); reset = 1'b0;
    total++; if (state_o !== 2'b00 || alarm_bcd !== 13'h0 || buzzer !== 1'b0)
      begin bad++; $display("FAIL rst_snooze state=%b alarm=%h buzzer=%b want=00,0000,0", state_o, alarm_bcd, buzzer); end
`endif
  endtask

  initial begin
    test_reset();
    test_adjust();
    test_wrap();
    test_match();
    test_ring_timeout();
    test_snooze();
    test_disarm();
    test_stop_snooze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
